// File: rtl/rc_servo_pkg.sv
// Shared definitions for the rc_servo XY datapath: ADC FSM encodings and the
// default code widths that the ADC and PWM stages must agree on.
package rc_servo_pkg;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned WINDOW_BITS_DEF = 10;
  localparam int unsigned OUT_BITS_DEF    = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACQ    = 2'd2
  } adc_state_e;

endpackage : rc_servo_pkg

// File: rtl/comp_sync_filter.sv
// Comparator front end: synchroniser chain followed by a registered 3-tap
// majority filter that removes single-sample glitches.
module comp_sync_filter #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic filt_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]             tap_q, tap_d;
  logic                   filt_q, filt_d;
  logic                   synced;

  // Majority of the current synced sample and the two before it.
  always_comb begin
    synced = sync_q[SYNC_STAGES-1];
    sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
    tap_d  = {tap_q[0], synced};
    filt_d = (synced & tap_q[0]) | (synced & tap_q[1]) | (tap_q[0] & tap_q[1]);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '0;
      tap_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      tap_q  <= tap_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o = filt_q;

endmodule : comp_sync_filter

// File: rtl/comp_duty_adc.sv
// Duty-cycle ADC: measures the filtered comparator high-time over a fixed
// window and publishes a truncated, saturated position code with a strobe.
module comp_duty_adc
  import rc_servo_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned WINDOW_BITS = WINDOW_BITS_DEF,
  parameter int unsigned OUT_BITS    = OUT_BITS_DEF
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                comp_async_i,
  input  logic                en_i,
  output logic [OUT_BITS-1:0] value_o,
  output logic                valid_o,
  output logic                busy_o
);

  localparam int unsigned SETTLE_LAST = SYNC_STAGES + 2;
  localparam int unsigned SETTLE_W    = $clog2(SYNC_STAGES + 3);

  adc_state_e             state_q, state_d;
  logic [WINDOW_BITS-1:0] win_cnt_q, win_cnt_d;
  logic [WINDOW_BITS-1:0] high_cnt_q, high_cnt_d;
  logic [SETTLE_W-1:0]    settle_cnt_q, settle_cnt_d;
  logic [OUT_BITS-1:0]    value_q, value_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;

  logic                   comp_f;
  logic                   win_last;
  logic [WINDOW_BITS:0]   sum;
  logic [WINDOW_BITS-1:0] sat_sum;

  comp_sync_filter #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_front (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .async_i(comp_async_i),
    .filt_o (comp_f)
  );

  // Closing sum includes the last cycle's sample; a fully-high window overflows.
  always_comb begin
    win_last = (win_cnt_q == {WINDOW_BITS{1'b1}});
    sum      = {1'b0, high_cnt_q} + (WINDOW_BITS+1)'(comp_f);
    sat_sum  = sum[WINDOW_BITS] ? {WINDOW_BITS{1'b1}} : sum[WINDOW_BITS-1:0];
  end

  always_comb begin
    state_d      = state_q;
    win_cnt_d    = win_cnt_q;
    high_cnt_d   = high_cnt_q;
    settle_cnt_d = settle_cnt_q;
    value_d      = value_q;
    valid_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        win_cnt_d    = '0;
        high_cnt_d   = '0;
        settle_cnt_d = '0;
        if (en_i) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!en_i) begin
          state_d      = ST_IDLE;
          settle_cnt_d = '0;
        end else if (settle_cnt_q == SETTLE_W'(SETTLE_LAST)) begin
          state_d      = ST_ACQ;
          settle_cnt_d = '0;
          win_cnt_d    = '0;
          high_cnt_d   = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
        end
      end
      ST_ACQ: begin
        if (win_last) begin
          value_d    = sat_sum[WINDOW_BITS-1 -: OUT_BITS];
          valid_d    = 1'b1;
          win_cnt_d  = '0;
          high_cnt_d = '0;
        end else begin
          win_cnt_d  = win_cnt_q + WINDOW_BITS'(1);
          high_cnt_d = high_cnt_q + WINDOW_BITS'(comp_f);
        end
        // A closing window still publishes even when enable drops with it.
        if (!en_i) begin
          state_d    = ST_IDLE;
          win_cnt_d  = '0;
          high_cnt_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      win_cnt_q    <= '0;
      high_cnt_q   <= '0;
      settle_cnt_q <= '0;
      value_q      <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_cnt_q    <= win_cnt_d;
      high_cnt_q   <= high_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      value_q      <= value_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
    end
  end

  assign value_o = value_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;

endmodule : comp_duty_adc

// File: tb/tb_comp_duty_adc.sv
// Directed bench for comp_duty_adc at default parameters (2 sync stages,
// 1024-cycle window, 8-bit code).
module tb_comp_duty_adc;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       comp_async_i = 1'b0;
  logic       en_i = 1'b0;
  logic [7:0] value_o;
  logic       valid_o;
  logic       busy_o;

  int comp_cnt = 0;
  int err_cnt  = 0;
  int mode     = 0;
  int cyc      = 0;
  int c;

  always #5 clk = ~clk;

  comp_duty_adc dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .comp_async_i(comp_async_i),
    .en_i        (en_i),
    .value_o     (value_o),
    .valid_o     (valid_o),
    .busy_o      (busy_o)
  );

  // Comparator pattern generator: 0 low, 1 high, 2 period-8 high-2, 3 glitches.
  always @(posedge clk) begin
    #2;
    cyc++;
    case (mode)
      0: comp_async_i = 1'b0;
      1: comp_async_i = 1'b1;
      2: comp_async_i = ((cyc % 8) < 2);
      default: comp_async_i = ((cyc % 16) == 0);
    endcase
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input int max, output int cycles);
    cycles = 0;
    do begin
      step(1);
      cycles++;
    end while (!valid_o && cycles < max);
  endtask

  task automatic start(input int m);
    en_i = 1'b0;
    mode = m;
    step(12);
    en_i = 1'b1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    en_i    = 1'b1;
    mode    = 1;
    step(4);
    comp_cnt++;
    if (value_o !== 8'h00) begin err_cnt++; $display("FAIL reset_value: got %h expected 00", value_o); end
    comp_cnt++;
    if (valid_o !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    comp_cnt++;
    if (busy_o !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    reset_i = 1'b0;
    en_i    = 1'b0;
    step(10);
  endtask

  task automatic test_zero();
    start(0);
    wait_valid(1100, c);
    comp_cnt++;
    if (!valid_o || c != 1030) begin err_cnt++; $display("FAIL zero_first_latency: got %0d expected 1030", c); end
    comp_cnt++;
    if (value_o !== 8'h00) begin err_cnt++; $display("FAIL zero_value: got %h expected 00", value_o); end
    step(1);
    comp_cnt++;
    if (valid_o !== 1'b0) begin err_cnt++; $display("FAIL strobe_width: got %b expected 0", valid_o); end
    wait_valid(1100, c);
    comp_cnt++;
    if (!valid_o || c + 1 != 1024) begin err_cnt++; $display("FAIL zero_period: got %0d expected 1024", c + 1); end
  endtask

  task automatic test_full();
    start(1);
    wait_valid(1100, c);
    comp_cnt++;
    if (!valid_o || c != 1030) begin err_cnt++; $display("FAIL full_latency: got %0d expected 1030", c); end
    comp_cnt++;
    if (value_o !== 8'hFF) begin err_cnt++; $display("FAIL full_value1: got %h expected ff", value_o); end
    wait_valid(1100, c);
    comp_cnt++;
    if (!valid_o || c != 1024) begin err_cnt++; $display("FAIL full_period: got %0d expected 1024", c); end
    comp_cnt++;
    if (value_o !== 8'hFF) begin err_cnt++; $display("FAIL full_value2: got %h expected ff", value_o); end
  endtask

  task automatic test_square();
    start(2);
    wait_valid(1100, c);
    comp_cnt++;
    if (!valid_o || value_o !== 8'h40) begin err_cnt++; $display("FAIL square_value1: got %h valid %b expected 40", value_o, valid_o); end
    wait_valid(1100, c);
    comp_cnt++;
    if (!valid_o || value_o !== 8'h40) begin err_cnt++; $display("FAIL square_value2: got %h valid %b expected 40", value_o, valid_o); end
  endtask

  task automatic test_glitch();
    start(3);
    wait_valid(1100, c);
    comp_cnt++;
    if (!valid_o || value_o !== 8'h00) begin err_cnt++; $display("FAIL glitch_value: got %h valid %b expected 00", value_o, valid_o); end
  endtask

  task automatic test_reset_mid();
    start(2);
    wait_valid(1100, c);
    comp_cnt++;
    if (!valid_o || value_o !== 8'h40) begin err_cnt++; $display("FAIL rmid_pre_value: got %h expected 40", value_o); end
    step(500);
    reset_i = 1'b1;
    step(1);
    reset_i = 1'b0;
    comp_cnt++;
    if (value_o !== 8'h00) begin err_cnt++; $display("FAIL rmid_value: got %h expected 00", value_o); end
    comp_cnt++;
    if (valid_o !== 1'b0) begin err_cnt++; $display("FAIL rmid_valid: got %b expected 0", valid_o); end
    comp_cnt++;
    if (busy_o !== 1'b0) begin err_cnt++; $display("FAIL rmid_busy: got %b expected 0", busy_o); end
    wait_valid(1100, c);
    comp_cnt++;
    if (!valid_o || c != 1030) begin err_cnt++; $display("FAIL rmid_latency: got %0d expected 1030", c); end
    comp_cnt++;
    if (value_o !== 8'h40) begin err_cnt++; $display("FAIL rmid_post_value: got %h expected 40", value_o); end
  endtask

  task automatic test_enable_drop();
    int n;
    // Continues from a strobe of 0x40 in square-wave mode.
    step(700);
    en_i = 1'b0;
    step(1);
    comp_cnt++;
    if (busy_o !== 1'b0) begin err_cnt++; $display("FAIL edrop_busy: got %b expected 0", busy_o); end
    comp_cnt++;
    if (valid_o !== 1'b0) begin err_cnt++; $display("FAIL edrop_valid: got %b expected 0", valid_o); end
    n = 0;
    for (int i = 0; i < 1200; i++) begin
      step(1);
      if (valid_o) n++;
    end
    comp_cnt++;
    if (n != 0) begin err_cnt++; $display("FAIL edrop_no_strobe: got %0d strobes expected 0", n); end
    comp_cnt++;
    if (value_o !== 8'h40) begin err_cnt++; $display("FAIL edrop_hold: got %h expected 40", value_o); end

    // Saturated window, then comp drops right after the strobe: the filter
    // keeps comp_f high for the first 4 window cycles -> sum 4 -> code 0x01.
    mode = 1;
    en_i = 1'b1;
    wait_valid(1100, c);
    comp_cnt++;
    if (!valid_o || value_o !== 8'hFF) begin err_cnt++; $display("FAIL close_pre_value: got %h valid %b expected ff", value_o, valid_o); end
    mode = 0;
    step(1023);
    en_i = 1'b0;
    step(1);
    comp_cnt++;
    if (valid_o !== 1'b1) begin err_cnt++; $display("FAIL close_valid: got %b expected 1", valid_o); end
    comp_cnt++;
    if (value_o !== 8'h01) begin err_cnt++; $display("FAIL close_value: got %h expected 01", value_o); end
    comp_cnt++;
    if (busy_o !== 1'b0) begin err_cnt++; $display("FAIL close_busy: got %b expected 0", busy_o); end
    step(1);
    comp_cnt++;
    if (valid_o !== 1'b0) begin err_cnt++; $display("FAIL close_strobe_end: got %b expected 0", valid_o); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_full();
    test_square();
    test_glitch();
    test_reset_mid();
    test_enable_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp_cnt, err_cnt);
    $finish;
  end

endmodule : tb_comp_duty_adc
